// File: rtl/cam_capture.sv
// OV7670 capture stage: oversamples the camera pins in the clk domain and writes RGB332 pixels to the frame buffer.
// Optional build macro CAM_CAPTURE_TEST_PATTERN_EN replaces pixel data with col ^ row.
module cam_capture #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_pclk,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [7:0]    DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          frame_done,
    output logic          ovf
);

    localparam int unsigned CW = $clog2(IMG_W + 1);
    localparam int unsigned RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);
    localparam logic [AW-1:0] LINE_LEN = AW'(IMG_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } state_t;

    // Two-flop synchronisers plus a third tap for edge detection on the control lines.
    logic [2:0] pclk_sr;
    logic [2:0] href_sr;
    logic [2:0] vs_sr;
    logic [7:0] data_s1;
    logic [7:0] data_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_sr <= '0;
            href_sr <= '0;
            vs_sr   <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            pclk_sr <= {pclk_sr[1:0], CAM_pclk};
            href_sr <= {href_sr[1:0], CAM_href};
            vs_sr   <= {vs_sr[1:0], CAM_vsync};
            data_s1 <= CAM_px_data;
            data_s2 <= data_s1;
        end
    end

    // Registered events; byte_d is the data delayed to line up with byte_ev.
    logic       byte_ev;
    logic       href_fall;
    logic       vs_fall;
    logic       vs_rise;
    logic       vs_high;
    logic [7:0] byte_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ev   <= 1'b0;
            href_fall <= 1'b0;
            vs_fall   <= 1'b0;
            vs_rise   <= 1'b0;
            vs_high   <= 1'b0;
            byte_d    <= '0;
        end else begin
            byte_ev   <= pclk_sr[1] & ~pclk_sr[2] & href_sr[1] & ~vs_sr[1];
            href_fall <= href_sr[2] & ~href_sr[1];
            vs_fall   <= vs_sr[2] & ~vs_sr[1];
            vs_rise   <= vs_sr[1] & ~vs_sr[2];
            vs_high   <= vs_sr[1];
            byte_d    <= data_s2;
        end
    end

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [5:0]    b1;
    logic          pix_valid;
    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    logic [7:0]    pix_data;

    // Capture FSM: pairs bytes into pixels and tracks the write position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            b1         <= '0;
            pix_valid  <= 1'b0;
            pix_col    <= '0;
            pix_row    <= '0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (vs_rise && state != IDLE) begin
                frame_done <= 1'b1;
                state      <= IDLE;
            end else if (vs_high) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (vs_fall) begin
                    col   <= '0;
                    row   <= '0;
                    ovf   <= 1'b0;
                    state <= BYTE1;
                end
            end else if (href_fall) begin
                state <= BYTE1;
                if (col != '0) begin
                    col <= '0;
                    if (row != ROW_MAX) begin
                        row <= RW'(row + 1'b1);
                    end
                end
            end else if (byte_ev) begin
                if (state == BYTE1) begin
                    b1    <= {byte_d[7:5], byte_d[2:0]};
                    state <= BYTE2;
                end else begin
                    state <= BYTE1;
                    if (col < COL_MAX && row < ROW_MAX) begin
                        pix_valid <= 1'b1;
                        pix_col   <= col;
                        pix_row   <= row;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
                        pix_data  <= 8'(col) ^ 8'(row);
`else
                        pix_data  <= {b1, byte_d[4:3]};
`endif
                    end else begin
                        ovf <= 1'b1;
                    end
                    if (col != COL_MAX) begin
                        col <= CW'(col + 1'b1);
                    end
                end
            end
        end
    end

    logic [AW-1:0] pix_addr_c;

    always_comb begin
        pix_addr_c = AW'(pix_row) * LINE_LEN + AW'(pix_col);
    end

    // Output register: address and data change only alongside a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
        end else begin
            DP_RAM_regW <= pix_valid;
            if (pix_valid) begin
                DP_RAM_addr_in <= pix_addr_c;
                DP_RAM_data_in <= pix_data;
            end
        end
    end

endmodule

// File: doc/cam_capture.md
# cam_capture

Camera-side capture stage between the OV7670 pins and the frame-buffer write port of `test_cam`. Oversamples `CAM_pclk`, `CAM_href`, `CAM_vsync` and `CAM_px_data` in the system `clk` domain and assembles RGB565 byte pairs into RGB332 pixels. Writes each pixel to the dual-port RAM at `row*IMG_W + col` for a 160x120 frame. Also reports end-of-frame and overflow.

## Interface
- `IMG_W`, 160, pixels per line (one pixel = 2 `CAM_pclk` bytes)
- `IMG_H`, 120, lines per frame
- `AW`, 15, RAM address width; must satisfy IMG_W*IMG_H <= 2^AW
- `clk`  in  1  system clock; the only clock in the block
- `rst`  in  1  asynchronous, active-high reset
- `CAM_pclk`  in  1  camera pixel clock, sampled as data
- `CAM_vsync`  in  1  frame sync: high = blanking, falling edge = frame start
- `CAM_href`  in  1  line valid, high during active bytes
- `CAM_px_data`  in  8  camera byte, stable around `CAM_pclk` rising edge
- `DP_RAM_addr_in`  out  AW  write address
- `DP_RAM_data_in`  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
- `DP_RAM_regW`  out  1  write strobe, one `clk` cycle per pixel
- `frame_done`  out  1  one-cycle pulse at end of an active frame
- `ovf`  out  1  sticky overflow: a pixel was dropped in the current frame

## Operation
- Input sync: `CAM_pclk`, `CAM_href`, `CAM_vsync` and `CAM_px_data` each pass through 2 flops. A third `pclk` flop feeds edge detection, with a matching delay on data and href so they stay aligned with the detected edge.
- Events:
  - byte event = synced pclk rising edge with synced href = 1
  - vs_fall / vs_rise = edges of synced vsync
  - href_fall = falling edge of synced href
- FSM states: IDLE, BYTE1, BYTE2.
- IDLE:
  - Ignores byte events.
  - On vs_fall: clear `col`, `row` and `ovf`, then go to BYTE1.
- BYTE1:
  - On a byte event: latch `b1 = CAM_px_data`, go to BYTE2.
- BYTE2:
  - On a byte event: emit pixel {b1[7:5], b1[2:0], byte[4:3]} (R565[4:2], G565[5:3], B565[4:3]), then go to BYTE1.
- Emit rule:
  - If `col < IMG_W` and `row < IMG_H`: assert `DP_RAM_regW` for 1 cycle with `DP_RAM_addr_in = row*IMG_W + col`.
  - Otherwise drop the pixel and set `ovf`.
  - `col` increments on every emitted or dropped pixel, saturating at IMG_W.
- href_fall in BYTE1 or BYTE2:
  - Discard any half pixel and return to BYTE1.
  - If `col != 0`: `row <= row+1` (saturating at IMG_H), `col <= 0`.
- vs_rise in BYTE1 or BYTE2:
  - Pulse `frame_done` for 1 cycle, go to IDLE.
  - Any half pixel is discarded.
- vsync high in any state forces IDLE; byte events are ignored while vsync is high.
- Simultaneous events:
  - vs_rise has priority over href_fall, which has priority over a byte event in the same cycle.
- Address arithmetic:
  - Computed as `row*IMG_W + col`, truncated to AW bits.
  - Never exceeds IMG_W*IMG_H-1 while `regW` is high.

## Timing
- Reset values: `DP_RAM_addr_in`=0, `DP_RAM_data_in`=0, `DP_RAM_regW`=0, `frame_done`=0, `ovf`=0, state IDLE, all sync flops 0.
- Input constraint: `CAM_pclk` high and low phases each span >= 2 `clk` cycles (nominal `clk` = 4x `pclk`).
- Latency: `DP_RAM_regW` rises 4 `clk` edges after the first `clk` edge that samples the second byte's `pclk` high. Address and data are valid in the same cycle as the strobe.
- `DP_RAM_regW` is never high on two consecutive cycles.
- `ovf` stays set until the next vs_fall, or reset.
- Reset mid-frame returns to IDLE immediately; capture resumes only after a full vsync high-to-low transition.

## Configuration
- `CAM_CAPTURE_TEST_PATTERN_EN`:
  - Defined: `DP_RAM_data_in = col[7:0] ^ row[7:0]` in place of the camera data. Timing, addressing, strobes and flags are unchanged.
  - Undefined: RGB332 derived from camera bytes as above.

## Test plan
- Reset then one frame of 160x120 with constant byte 8'hE0 -> 19200 strobes, data 8'hE0 on each, last address 19199, one `frame_done`, `ovf`=0.
- Line of 2 bytes 8'hF8,8'h1F -> data 8'b11100011, address 0.
- Line of 330 bytes (165 pixels) -> 160 writes at addresses 0..159, 5 drops, `ovf`=1; next line starts at address 160.
- href falls after 3 bytes -> one write only, no half pixel written; next line's first pixel at address 160.
- 125 lines in a frame -> addresses stop at 19199, `ovf`=1; next vs_fall clears `ovf` and restarts at address 0.
- `rst` pulsed during line 10 -> all outputs 0 within one cycle; no writes until after vsync high then low; next frame starts at address 0.
